// File: rtl/inst_fetch_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared constants for the instruction-fetch stage and its IF/ID register.
//   NOP_INST         : instruction word written into IF/ID on a flush
//   INST_WIDTH       : width of an instruction word and of the PC
//   PC_STEP          : byte distance between sequential instructions
//   DEFAULT_RESET_PC : PC loaded at reset unless the top overrides it
// ----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam int          INST_WIDTH       = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register: instruction word, fetch PC + 4 and a valid flag.
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   i_hold       : keep all outputs unchanged this edge
//   i_flush      : replace contents with a NOP bubble (wins over i_hold)
//   i_inst       : instruction word to capture
//   i_pc_plus4   : fetch PC + 4 to capture
//   o_inst       : registered instruction
//   o_pc_plus4   : registered fetch PC + 4
//   o_valid      : 1 = o_inst is a real fetched instruction, 0 = bubble
// Priority on each edge: reset > flush > hold > load.
// ----------------------------------------------------------------------------
module if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_hold,
    input  logic                  i_flush,
    input  logic [INST_WIDTH-1:0] i_inst,
    input  logic [INST_WIDTH-1:0] i_pc_plus4,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [INST_WIDTH-1:0] o_pc_plus4,
    output logic                  o_valid
);

    logic [INST_WIDTH-1:0] r_inst;
    logic [INST_WIDTH-1:0] r_pc_plus4;
    logic                  r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inst     <= NOP_INST;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_inst     <= NOP_INST;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (!i_hold) begin
            r_inst     <= i_inst;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_inst     = r_inst;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory address, and captures the returned word into the IF/ID register.
// Ports:
//   clk             : rising-edge clock
//   rst_n           : synchronous active-low reset (PC <= RESET_PC)
//   stall           : hazard hold; PC, IF/ID and fetch_count keep their values
//   redirect        : taken branch/jump; load redirect_target, flush IF/ID
//   redirect_target : new PC, low two bits ignored (word aligned)
//   imem_addr       : byte address to instruction memory (= PC, no latency)
//   imem_data       : instruction word for imem_addr, same cycle
//   if_id_inst      : registered instruction to decode
//   if_id_pc_plus4  : registered fetch PC + 4
//   if_id_valid     : 1 = if_id_inst is a real instruction, 0 = bubble/reset
//   fetch_count     : instructions accepted into IF/ID (wraps silently)
// if_id_valid has no ready partner: decode consumes on every edge, and the
// hazard unit expresses back-pressure through stall instead.
// Priority on each edge: reset > redirect > stall > advance.
// ----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_fetch_count;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;

    // Natural 32-bit overflow gives the required modulo-2^32 PC wrap.
    assign w_pc_plus4    = r_pc + PC_STEP;
    // Force word alignment of branch/jump targets.
    assign w_redirect_pc = redirect_target & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else if (redirect) begin
            // Target is fetched on the very next cycle; count holds since the
            // IF/ID slot receives a bubble, not an accepted instruction.
            r_pc <= w_redirect_pc;
        end else if (!stall) begin
            r_pc          <= w_pc_plus4;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_hold     (stall),
        .i_flush    (redirect),
        .i_inst     (imem_data),
        .i_pc_plus4 (w_pc_plus4),
        .o_inst     (if_id_inst),
        .o_pc_plus4 (if_id_pc_plus4),
        .o_valid    (if_id_valid)
    );

    assign imem_addr   = r_pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the single clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port stall  input  1  hazard-unit hold request (load-use).
REQ-005 SHALL have port redirect  input  1  taken branch or jump.
REQ-006 SHALL have port redirect_target  input  32  new PC when redirect=1.
REQ-007 SHALL have port imem_addr  output  32  byte address to the combinational instruction memory.
REQ-008 SHALL have port imem_data  input  32  instruction word returned in the same cycle for imem_addr.
REQ-009 SHALL have port if_id_inst  output  32  registered instruction to decode.
REQ-010 SHALL have port if_id_pc_plus4  output  32  registered fetch PC + 4.
REQ-011 SHALL have port if_id_valid  output  1  registered flag; 1 = if_id_inst is a real fetched instruction.
REQ-012 SHALL have port fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-013 SHALL drive imem_addr = pc combinationally, with no added latency.
REQ-014 SHALL present an instruction on if_id_* exactly one cycle after its address appears on imem_addr.
REQ-015 Advance (rst_n=1, redirect=0, stall=0): pc<=pc+4; if_id_inst<=imem_data; if_id_pc_plus4<=pc+4; if_id_valid<=1; fetch_count<=fetch_count+1.
REQ-016 Stall (rst_n=1, redirect=0, stall=1): pc, all if_id_* and fetch_count SHALL hold their values.
REQ-017 Redirect (rst_n=1, redirect=1): pc<=redirect_target with bits [1:0] forced to 00; if_id_inst<=32'h0 (NOP); if_id_valid<=0; if_id_pc_plus4<=0; fetch_count holds.
REQ-018 Priority SHALL be reset > redirect > stall > advance; redirect with stall=1 still loads the target and flushes IF/ID.
REQ-019 PC arithmetic SHALL be modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000, and if_id_pc_plus4 holds 32'h0000_0000.
REQ-020 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0 without flagging.
REQ-021 The block SHALL decode no instruction content; imem_data SHALL pass through unmodified.
REQ-022 The cycle immediately after a redirect SHALL fetch from the target; no second bubble is inserted.

Reset
REQ-023 When rst_n=0 at a clk edge: pc<=RESET_PC; if_id_inst<=32'h0; if_id_pc_plus4<=0; if_id_valid<=0; fetch_count<=0.
REQ-024 Reset SHALL override stall and redirect in the same cycle.
REQ-025 When reset is asserted mid-stream, the next edge with rst_n=1 SHALL fetch from RESET_PC.
REQ-026 Outputs SHALL change only on clk edges; there is no asynchronous path from rst_n.

Structure
REQ-027 A shared package SHALL hold NOP_INST (32'h0), INST_WIDTH (32), PC_STEP (4) and the default RESET_PC.
REQ-028 The IF/ID register set (inst, pc_plus4, valid with hold and flush controls) SHALL be one sub-module, if_id_reg; PC register, adder and fetch_count SHALL stay in inst_fetch.
REQ-029 The block SHALL use no memories and no multi-cycle state beyond the registers listed above.

Verification
REQ-030 Reset, then 4 free-running cycles, memory word[i]=i+1: imem_addr = 0,4,8,C; if_id_inst = 1,2,3; if_id_valid=1 from cycle 2; fetch_count=3 after the 4th edge.
REQ-031 Stall held for 2 cycles with pc=8: imem_addr stays 8, if_id_* and fetch_count unchanged, and advance resumes with if_id_inst=word[2].
REQ-032 Redirect with target 32'h0000_0043 and stall=1 simultaneously: next pc=32'h0000_0040, if_id_valid=0, if_id_inst=0; the following cycle if_id_inst=word[16], valid=1.
REQ-033 RESET_PC=32'hFFFF_FFFC: after one advance pc=0 and if_id_pc_plus4=0.
REQ-034 rst_n driven low for one edge while pc=32'h20, with stall and redirect both 1: all outputs return to their reset values and imem_addr=RESET_PC.
